// File: rtl/modulo_escalonador_buffers_rolhas.sv
// ============================================================================
// Module   : modulo_escalonador_buffers_rolhas
// Brief    : Cork buffer scheduler. Owns the secundario (0..99) and principal
//            (0..31) buffers and arbitrates the secundario counter between
//            operator reloads (LOAD) and automatic transfers (XFER).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modulo_escalonador_buffers_rolhas #(
  parameter int MAX_SEC      = 99,
  parameter int MAX_PRI      = 31,
  parameter int MIN_PRI      = 5,
  parameter int TRANSFER_QTY = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       op_req,
  input  logic [6:0] op_qty,
  input  logic       seal_pulse,
  output logic [6:0] sec_count,
  output logic [4:0] pri_count,
  output logic       op_ack,
  output logic       op_reject,
  output logic       xfer_done,
  output logic       low_stock,
  output logic       ro,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_XFER = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [7:0] c_max_sec  = 8'(MAX_SEC);
  localparam logic [4:0] c_max_pri  = 5'(MAX_PRI);
  localparam logic [4:0] c_min_pri  = 5'(MIN_PRI);
  localparam logic [6:0] c_xfer_qty = 7'(TRANSFER_QTY);

  state_t     r_state, w_state_nx;
  logic [6:0] r_sec, w_sec_nx;
  logic [4:0] r_pri, w_pri_nx;
  logic [6:0] r_rem, w_rem_nx;
  logic       r_pend, w_pend_nx;
  logic [6:0] r_pend_qty, w_pend_qty_nx;
  logic       r_ack, w_ack_nx;
  logic       r_rej, w_rej_nx;
  logic       r_done, w_done_nx;

  logic [7:0] w_sum;
  logic       w_accept;
  logic       w_qty_nz;
  logic [4:0] w_pri_dec;
  logic [4:0] w_pri_inc;

  // 8-bit sum so a full secundario plus a large request cannot wrap
  assign w_sum     = {1'b0, r_sec} + {1'b0, op_qty};
  assign w_accept  = op_req && !r_pend && (r_state != S_LOAD) && (w_sum <= c_max_sec);
  assign w_qty_nz  = (op_qty != 7'd0);
  assign w_pri_dec = (r_pri != 5'd0) ? (r_pri - 5'd1) : r_pri;
  assign w_pri_inc = (r_pri != c_max_pri) ? (r_pri + 5'd1) : r_pri;

  // State register and all counters; clr drops everything, including pending work
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_sec      <= 7'd0;
      r_pri      <= 5'd0;
      r_rem      <= 7'd0;
      r_pend     <= 1'b0;
      r_pend_qty <= 7'd0;
      r_ack      <= 1'b0;
      r_rej      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_sec      <= w_sec_nx;
      r_pri      <= w_pri_nx;
      r_rem      <= w_rem_nx;
      r_pend     <= w_pend_nx;
      r_pend_qty <= w_pend_qty_nx;
      r_ack      <= w_ack_nx;
      r_rej      <= w_rej_nx;
      r_done     <= w_done_nx;
    end
  end

  // Next-state, counter updates and request arbitration
  always_comb begin
    w_state_nx    = r_state;
    w_sec_nx      = r_sec;
    w_pri_nx      = r_pri;
    w_rem_nx      = r_rem;
    w_pend_nx     = r_pend;
    w_pend_qty_nx = r_pend_qty;
    w_ack_nx      = w_accept;
    w_rej_nx      = op_req && !w_accept;
    w_done_nx     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (seal_pulse) w_pri_nx = w_pri_dec;
        // Operator work (fresh or deferred) outranks replenishing principal
        if (w_accept && w_qty_nz) begin
          w_state_nx = S_LOAD;
          w_rem_nx   = op_qty;
        end else if (r_pend) begin
          w_state_nx = S_LOAD;
          w_rem_nx   = r_pend_qty;
          w_pend_nx  = 1'b0;
        end else if ((r_pri < c_min_pri) && (r_sec >= c_xfer_qty)) begin
          w_state_nx = S_XFER;
          w_rem_nx   = c_xfer_qty;
        end
      end

      S_LOAD: begin
        if (seal_pulse) w_pri_nx = w_pri_dec;
        w_sec_nx = r_sec + 7'd1;
        w_rem_nx = r_rem - 7'd1;
        if (r_rem == 7'd1) w_state_nx = S_IDLE;
      end

      S_XFER: begin
        // Sealing has the principal buffer this cycle; the transfer waits
        if (seal_pulse) begin
          w_pri_nx = w_pri_dec;
        end else begin
          w_sec_nx = r_sec - 7'd1;
          w_pri_nx = w_pri_inc;
          w_rem_nx = r_rem - 7'd1;
          if (r_rem == 7'd1) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end
        end
        if (w_accept && w_qty_nz) begin
          w_pend_nx     = 1'b1;
          w_pend_qty_nx = op_qty;
        end
      end

      default: begin
        // Illegal encoding: return to IDLE with counts held
        w_state_nx = S_IDLE;
        if (w_accept && w_qty_nz) begin
          w_pend_nx     = 1'b1;
          w_pend_qty_nx = op_qty;
        end
      end
    endcase
  end

  assign sec_count = r_sec;
  assign pri_count = r_pri;
  assign op_ack    = r_ack;
  assign op_reject = r_rej;
  assign xfer_done = r_done;
  assign low_stock = (r_sec < c_xfer_qty);
  assign ro        = (r_pri == 5'd0);
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_modulo_escalonador_buffers_rolhas.sv
// ============================================================================
// Module   : tb_modulo_escalonador_buffers_rolhas
// Brief    : Self-checking bench for the cork buffer scheduler: directed
//            scenarios plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modulo_escalonador_buffers_rolhas;

  logic       clk;
  logic       clr;
  logic       op_req;
  logic [6:0] op_qty;
  logic       seal_pulse;
  logic [6:0] sec_count;
  logic [4:0] pri_count;
  logic       op_ack;
  logic       op_reject;
  logic       xfer_done;
  logic       low_stock;
  logic       ro;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: modes 0 idle, 1 reload, 2 transfer
  int m_mode, m_sec, m_pri, m_rem;
  int m_pend[$];
  bit m_ack, m_rej, m_done;

  modulo_escalonador_buffers_rolhas dut (
    .clk        (clk),
    .clr        (clr),
    .op_req     (op_req),
    .op_qty     (op_qty),
    .seal_pulse (seal_pulse),
    .sec_count  (sec_count),
    .pri_count  (pri_count),
    .op_ack     (op_ack),
    .op_reject  (op_reject),
    .xfer_done  (xfer_done),
    .low_stock  (low_stock),
    .ro         (ro),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_sec = 0; m_pri = 0; m_rem = 0;
    m_pend.delete();
    m_ack = 0; m_rej = 0; m_done = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  task automatic tick(input bit req, input int qty, input bit seal);
    int  s0, p0;
    bit  acc;
    op_req     = req;
    op_qty     = 7'(qty);
    seal_pulse = seal;
    @(posedge clk);
    #1;
    s0  = m_sec;
    p0  = m_pri;
    acc = req && (m_pend.size() == 0) && (m_mode != 1) && (s0 + qty <= 99);
    m_ack  = acc;
    m_rej  = req && !acc;
    m_done = 0;
    if (m_mode == 0) begin
      if (seal && p0 > 0) m_pri = p0 - 1;
      if (acc && qty > 0) begin
        m_mode = 1; m_rem = qty;
      end else if (m_pend.size() > 0) begin
        m_mode = 1; m_rem = m_pend.pop_front();
      end else if (p0 < 5 && s0 >= 20) begin
        m_mode = 2; m_rem = 20;
      end
    end else if (m_mode == 1) begin
      if (seal && p0 > 0) m_pri = p0 - 1;
      m_sec = s0 + 1;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_mode = 0;
    end else begin
      if (seal) begin
        if (p0 > 0) m_pri = p0 - 1;
      end else begin
        m_sec = s0 - 1;
        m_pri = p0 + 1;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode = 0; m_done = 1;
        end
      end
      if (acc && qty > 0) m_pend.push_back(qty);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic do_reset();
    op_req = 0; op_qty = 0; seal_pulse = 0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state !== 2'b00) $display("FAIL rst_state: got %b want 00", state); else n_pass++;
    n_checks++; if (sec_count !== 7'd0) $display("FAIL rst_sec: got %0d want 0", sec_count); else n_pass++;
    n_checks++; if (pri_count !== 5'd0) $display("FAIL rst_pri: got %0d want 0", pri_count); else n_pass++;
    n_checks++; if ({op_ack, op_reject, xfer_done} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {op_ack, op_reject, xfer_done}); else n_pass++;
    n_checks++; if ({ro, low_stock} !== 2'b11) $display("FAIL rst_flags: got %b want 11", {ro, low_stock}); else n_pass++;
    // Start a reload, get a reject pulse going, then reset asynchronously mid-cycle
    tick(1, 30, 0);
    tick(1, 5, 0);
    n_checks++; if (op_reject !== 1'b1) $display("FAIL rst_prerej: got %b want 1", op_reject); else n_pass++;
    #2 clr = 1'b0;
    #1;
    n_checks++; if (state !== 2'b00) $display("FAIL arst_state: got %b want 00", state); else n_pass++;
    n_checks++; if (sec_count !== 7'd0) $display("FAIL arst_sec: got %0d want 0", sec_count); else n_pass++;
    n_checks++; if (op_reject !== 1'b0) $display("FAIL arst_rej: got %b want 0", op_reject); else n_pass++;
    @(posedge clk);
    #1;
    clr = 1'b1;
    model_reset();
    idle(3);
    n_checks++; if (state !== 2'b00 || sec_count !== 7'd0 || pri_count !== 5'd0) $display("FAIL rst_after: got st=%b sec=%0d pri=%0d want 00/0/0", state, sec_count, pri_count); else n_pass++;
  endtask

  task automatic test_load_xfer();
    do_reset();
    tick(1, 30, 0);
    n_checks++; if (op_ack !== 1'b1 || state !== 2'b01) $display("FAIL lx_accept: got ack=%b st=%b want 1/01", op_ack, state); else n_pass++;
    idle(29);
    n_checks++; if (state !== 2'b01 || sec_count !== 7'd29) $display("FAIL lx_load29: got st=%b sec=%0d want 01/29", state, sec_count); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (state !== 2'b00 || sec_count !== 7'd30) $display("FAIL lx_loaded: got st=%b sec=%0d want 00/30", state, sec_count); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (state !== 2'b10) $display("FAIL lx_xfer_start: got %b want 10", state); else n_pass++;
    idle(19);
    n_checks++; if (state !== 2'b10 || xfer_done !== 1'b0) $display("FAIL lx_xfer19: got st=%b done=%b want 10/0", state, xfer_done); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (sec_count !== 7'd10 || pri_count !== 5'd20) $display("FAIL lx_counts: got sec=%0d pri=%0d want 10/20", sec_count, pri_count); else n_pass++;
    n_checks++; if (xfer_done !== 1'b1 || state !== 2'b00) $display("FAIL lx_done: got done=%b st=%b want 1/00", xfer_done, state); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (xfer_done !== 1'b0 || state !== 2'b00) $display("FAIL lx_after: got done=%b st=%b want 0/00", xfer_done, state); else n_pass++;
  endtask

  task automatic test_overflow();
    // Continues from sec=10, pri=20
    tick(1, 80, 0);
    idle(80);
    n_checks++; if (sec_count !== 7'd90 || state !== 2'b00) $display("FAIL ov_fill: got sec=%0d st=%b want 90/00", sec_count, state); else n_pass++;
    tick(1, 10, 0);
    n_checks++; if (op_reject !== 1'b1 || op_ack !== 1'b0) $display("FAIL ov_reject: got rej=%b ack=%b want 1/0", op_reject, op_ack); else n_pass++;
    n_checks++; if (sec_count !== 7'd90 || state !== 2'b00) $display("FAIL ov_hold: got sec=%0d st=%b want 90/00", sec_count, state); else n_pass++;
    tick(1, 9, 0);
    n_checks++; if (op_ack !== 1'b1 || op_reject !== 1'b0) $display("FAIL ov_ack99: got ack=%b rej=%b want 1/0", op_ack, op_reject); else n_pass++;
    idle(9);
    n_checks++; if (sec_count !== 7'd99 || low_stock !== 1'b0 || state !== 2'b00) $display("FAIL ov_full: got sec=%0d low=%b st=%b want 99/0/00", sec_count, low_stock, state); else n_pass++;
  endtask

  task automatic test_seal_pause();
    do_reset();
    tick(1, 30, 0);
    idle(30);
    tick(0, 0, 0);
    idle(8);
    n_checks++; if (sec_count !== 7'd22 || pri_count !== 5'd8) $display("FAIL sp_pre: got sec=%0d pri=%0d want 22/8", sec_count, pri_count); else n_pass++;
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    n_checks++; if (sec_count !== 7'd22 || pri_count !== 5'd5 || state !== 2'b10) $display("FAIL sp_paused: got sec=%0d pri=%0d st=%b want 22/5/10", sec_count, pri_count, state); else n_pass++;
    idle(11);
    n_checks++; if (state !== 2'b10 || xfer_done !== 1'b0) $display("FAIL sp_extra: got st=%b done=%b want 10/0", state, xfer_done); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (pri_count !== 5'd17 || sec_count !== 7'd10 || xfer_done !== 1'b1) $display("FAIL sp_final: got pri=%0d sec=%0d done=%b want 17/10/1", pri_count, sec_count, xfer_done); else n_pass++;
  endtask

  task automatic test_pending();
    do_reset();
    tick(1, 30, 0);
    idle(30);
    tick(0, 0, 0);
    tick(1, 5, 0);
    n_checks++; if (op_ack !== 1'b1 || state !== 2'b10) $display("FAIL pd_ack: got ack=%b st=%b want 1/10", op_ack, state); else n_pass++;
    tick(1, 3, 0);
    n_checks++; if (op_reject !== 1'b1 || op_ack !== 1'b0) $display("FAIL pd_second: got rej=%b ack=%b want 1/0", op_reject, op_ack); else n_pass++;
    idle(17);
    tick(0, 0, 0);
    n_checks++; if (xfer_done !== 1'b1 || state !== 2'b00 || sec_count !== 7'd10) $display("FAIL pd_xdone: got done=%b st=%b sec=%0d want 1/00/10", xfer_done, state, sec_count); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (state !== 2'b01 || op_ack !== 1'b0) $display("FAIL pd_loadstart: got st=%b ack=%b want 01/0", state, op_ack); else n_pass++;
    idle(4);
    n_checks++; if (state !== 2'b01) $display("FAIL pd_loading: got %b want 01", state); else n_pass++;
    tick(0, 0, 0);
    n_checks++; if (state !== 2'b00 || sec_count !== 7'd15 || pri_count !== 5'd20) $display("FAIL pd_end: got st=%b sec=%0d pri=%0d want 00/15/20", state, sec_count, pri_count); else n_pass++;
  endtask

  task automatic test_empty_seal();
    do_reset();
    tick(0, 0, 1);
    n_checks++; if (pri_count !== 5'd0 || ro !== 1'b1 || state !== 2'b00) $display("FAIL es_empty: got pri=%0d ro=%b st=%b want 0/1/00", pri_count, ro, state); else n_pass++;
    tick(1, 0, 0);
    n_checks++; if (op_ack !== 1'b1 || state !== 2'b00 || sec_count !== 7'd0) $display("FAIL es_qty0: got ack=%b st=%b sec=%0d want 1/00/0", op_ack, state, sec_count); else n_pass++;
    tick(1, 35, 0);
    idle(35);
    tick(0, 0, 0);
    idle(20);
    for (int i = 0; i < 17; i++) tick(0, 0, 1);
    idle(2);
    n_checks++; if (state !== 2'b00 || pri_count !== 5'd3 || sec_count !== 7'd15) $display("FAIL es_noxfer: got st=%b pri=%0d sec=%0d want 00/3/15", state, pri_count, sec_count); else n_pass++;
    n_checks++; if (low_stock !== 1'b1 || ro !== 1'b0) $display("FAIL es_flags: got low=%b ro=%b want 1/0", low_stock, ro); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 45), $urandom_range(0, 3) == 0);
      n_checks++; if (sec_count !== 7'(m_sec)) $display("FAIL rnd_sec c%0d: got %0d want %0d", c, sec_count, m_sec); else n_pass++;
      n_checks++; if (pri_count !== 5'(m_pri)) $display("FAIL rnd_pri c%0d: got %0d want %0d", c, pri_count, m_pri); else n_pass++;
      n_checks++; if (state !== 2'(m_mode)) $display("FAIL rnd_state c%0d: got %b want %0d", c, state, m_mode); else n_pass++;
      n_checks++; if (op_ack !== m_ack) $display("FAIL rnd_ack c%0d: got %b want %b", c, op_ack, m_ack); else n_pass++;
      n_checks++; if (op_reject !== m_rej) $display("FAIL rnd_rej c%0d: got %b want %b", c, op_reject, m_rej); else n_pass++;
      n_checks++; if (xfer_done !== m_done) $display("FAIL rnd_done c%0d: got %b want %b", c, xfer_done, m_done); else n_pass++;
      n_checks++; if (low_stock !== (m_sec < 20)) $display("FAIL rnd_low c%0d: got %b want %b", c, low_stock, m_sec < 20); else n_pass++;
      n_checks++; if (ro !== (m_pri == 0)) $display("FAIL rnd_ro c%0d: got %b want %b", c, ro, m_pri == 0); else n_pass++;
    end
  endtask

  initial begin
    clr = 1'b0; op_req = 1'b0; op_qty = 7'd0; seal_pulse = 1'b0;
    model_reset();
    test_reset();
    test_load_xfer();
    test_overflow();
    test_seal_pause();
    test_pending();
    test_empty_seal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
